// File: rtl/bsg_mem_1rw_sync_mask_fifo_out_if.sv
// Request/response bundle for bsg_mem_1rw_sync_mask_fifo_out.
// master = requester/consumer side, slave = memory side.
interface bsg_mem_1rw_sync_mask_fifo_out_if #(
    parameter int unsigned width_p = 64,
    parameter int unsigned els_p   = 512
);
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned mask_width_lp = width_p / 8;

    logic                     v_i;
    logic                     w_i;
    logic [addr_width_lp-1:0] addr_i;
    logic [width_p-1:0]       data_i;
    logic [mask_width_lp-1:0] w_mask_i;
    logic                     ready_o;
    logic                     v_o;
    logic [width_p-1:0]       data_o;
    logic                     yumi_i;

    modport master (
        output v_i, w_i, addr_i, data_i, w_mask_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, w_mask_i, yumi_i,
        output ready_o, v_o, data_o
    );
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_fifo_out.sv
// 1RW sync RAM with byte-masked writes, credit-gated reads and a small output FIFO.
// Define BSG_MEM_1RW_SYNC_MASK_FIFO_OUT_INIT_EN to zero the array after every reset.
module bsg_mem_1rw_sync_mask_fifo_out #(
    parameter int unsigned width_p   = 64,
    parameter int unsigned els_p     = 512,
    parameter int unsigned out_els_p = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_mem_1rw_sync_mask_fifo_out_if.slave bus
);
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned mask_width_lp = width_p / 8;
    localparam int unsigned cnt_w_lp      = $clog2(out_els_p + 1);
    localparam int unsigned ptr_w_lp      = $clog2(out_els_p);
    localparam int unsigned sum_w_lp      = cnt_w_lp + 1;

`ifdef BSG_MEM_1RW_SYNC_MASK_FIFO_OUT_INIT_EN
    typedef enum logic [1:0] {eRESET = 2'd0, eINIT = 2'd1, eREADY = 2'd2} state_e;
`else
    typedef enum logic [1:0] {eRESET = 2'd0, eREADY = 2'd2} state_e;
`endif

    state_e                   state_r;
    logic                     inflight_r;
    logic [cnt_w_lp-1:0]      cnt_r;
    logic [ptr_w_lp-1:0]      head_r;
    logic [width_p-1:0]       sram_q_r;
    logic [width_p-1:0]       fifo_r [out_els_p];
    logic [width_p-1:0]       mem_r  [els_p];

    logic                     accept_c;
    logic                     rd_c;
    logic                     wr_c;
    logic                     deq_c;
    logic                     enq_c;
    logic [sum_w_lp-1:0]      credit_c;
    logic [sum_w_lp-1:0]      wr_sum_c;
    logic [ptr_w_lp-1:0]      wr_idx_c;
    logic [ptr_w_lp-1:0]      head_inc_c;
    logic [addr_width_lp-1:0] addr_eff_c;

    logic                     mem_we_c;
    logic [addr_width_lp-1:0] mem_addr_c;
    logic [width_p-1:0]       mem_data_c;
    logic [mask_width_lp-1:0] mem_mask_c;

`ifdef BSG_MEM_1RW_SYNC_MASK_FIFO_OUT_INIT_EN
    logic [addr_width_lp-1:0] init_cnt_r;
`endif

    assign addr_eff_c = (els_p == 1) ? '0 : bus.addr_i;
    assign accept_c   = bus.v_i & bus.ready_o & reset_n_i;
    assign rd_c       = accept_c & ~bus.w_i;
    assign wr_c       = accept_c &  bus.w_i;

    // A read in flight with an empty FIFO and a taking consumer bypasses the FIFO entirely.
    assign deq_c = bus.yumi_i & (cnt_r != '0);
    assign enq_c = inflight_r & ~((cnt_r == '0) & bus.yumi_i);

    // Credits: slots already owed (buffered + in flight) minus the one leaving this cycle.
    assign credit_c    = sum_w_lp'(cnt_r) + sum_w_lp'(inflight_r) - sum_w_lp'(bus.yumi_i & bus.v_o);
    assign bus.ready_o = (state_r == eREADY) & (credit_c < sum_w_lp'(out_els_p));

    assign bus.v_o    = (cnt_r != '0) | inflight_r;
    assign bus.data_o = (cnt_r == '0) ? sram_q_r : fifo_r[head_r];

    // Tail slot is head+count modulo depth; with a simultaneous dequeue from full it reuses head.
    assign wr_sum_c   = sum_w_lp'(head_r) + sum_w_lp'(cnt_r);
    assign wr_idx_c   = (wr_sum_c >= sum_w_lp'(out_els_p)) ? ptr_w_lp'(wr_sum_c - sum_w_lp'(out_els_p))
                                                           : ptr_w_lp'(wr_sum_c);
    assign head_inc_c = (head_r == ptr_w_lp'(out_els_p - 1)) ? '0 : head_r + ptr_w_lp'(1);

    // Single write port, shared by the init sweep and accepted writes.
    always_comb begin
        mem_we_c   = wr_c;
        mem_addr_c = addr_eff_c;
        mem_data_c = bus.data_i;
        mem_mask_c = bus.w_mask_i;
`ifdef BSG_MEM_1RW_SYNC_MASK_FIFO_OUT_INIT_EN
        if (state_r == eINIT) begin
            mem_we_c   = 1'b1;
            mem_addr_c = init_cnt_r;
            mem_data_c = '0;
            mem_mask_c = '1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            for (int unsigned k = 0; k < mask_width_lp; k++) begin
                if (mem_mask_c[k]) mem_r[mem_addr_c][8*k +: 8] <= mem_data_c[8*k +: 8];
            end
        end
        if (rd_c) sram_q_r <= mem_r[addr_eff_c];
    end

    always_ff @(posedge clk_i) begin
        if (enq_c) fifo_r[wr_idx_c] <= sram_q_r;
    end

    // Control state: FSM, credits and FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= eRESET;
            inflight_r <= 1'b0;
            cnt_r      <= '0;
            head_r     <= '0;
`ifdef BSG_MEM_1RW_SYNC_MASK_FIFO_OUT_INIT_EN
            init_cnt_r <= '0;
`endif
        end else begin
            inflight_r <= rd_c;
            cnt_r      <= cnt_r + cnt_w_lp'(enq_c) - cnt_w_lp'(deq_c);
            if (deq_c) head_r <= head_inc_c;
            case (state_r)
`ifdef BSG_MEM_1RW_SYNC_MASK_FIFO_OUT_INIT_EN
                eRESET: state_r <= eINIT;
                eINIT: begin
                    if (init_cnt_r == addr_width_lp'(els_p - 1)) state_r <= eREADY;
                    else init_cnt_r <= init_cnt_r + addr_width_lp'(1);
                end
`else
                eRESET: state_r <= eREADY;
`endif
                eREADY:  state_r <= eREADY;
                default: state_r <= eRESET;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic seen_clk_r;

    always_ff @(posedge clk_i) begin
        seen_clk_r <= 1'b1;
        if (seen_clk_r) assert (!$isunknown(reset_n_i));
        if (reset_n_i) begin
            if (bus.v_i && bus.ready_o) assert ((els_p == 1) || (32'(bus.addr_i) < els_p));
            assert (!(bus.yumi_i && !bus.v_o));
        end
    end
`endif

endmodule

// File: doc/bsg_mem_1rw_sync_mask_fifo_out.md
Name: bsg_mem_1rw_sync_mask_fifo_out

Overview:
- Single-port synchronous RAM with a byte write mask and a valid/ready request interface.
- Read data is returned through a 2-entry output FIFO with a valid/yumi handshake, so consumers may stall without losing read data.
- Generalises the plain 1RW sync RAM with:
  - flow control,
  - credit-based read admission,
  - a reset/init state machine,
  - masked writes.
- Sits between cache/NoC endpoints and an SRAM macro or its inferred equivalent.

Parameters:
- width_p, 64: data width in bits. Must be a multiple of 8 and at least 8.
- els_p, 512: number of words. Must be at least 1.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p)`: address width (derived).
- mask_width_lp, width_p/8: write-mask width, one bit per byte (derived).
- out_els_p, 2: output FIFO depth. Legal values are 2..4.

Ports:
- clk_i, input, 1: clock. All state updates on posedge.
- reset_n_i, input, 1: synchronous, active-low reset.
- v_i, input, 1: request valid.
- w_i, input, 1: 1 = write, 0 = read.
- addr_i, input, addr_width_lp: word address. Ignored when els_p==1.
- data_i, input, width_p: write data.
- w_mask_i, input, mask_width_lp: byte enables for writes. Bit k enables bits [8k+7:8k].
- ready_o, output, 1: request accepted this cycle iff v_i & ready_o.
- v_o, output, 1: read data valid.
- data_o, output, width_p: read data.
- yumi_i, input, 1: consumer takes data_o. Only legal when v_o=1.

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - FSM goes to eRESET.
  - FIFO is emptied and in-flight flag is cleared.
  - ready_o=0, v_o=0; data_o is don't-care.
  - Memory contents are not cleared unless the optional feature is enabled.
- FSM states:
  - eRESET → eREADY on the first posedge with reset_n_i=1 (optional feature inserts eINIT between them).
  - eREADY persists until the next reset.
- Credits:
  - inflight_r is set for one cycle after an accepted read.
  - cnt_r is the FIFO occupancy.
  - ready_o = (state==eREADY) & (cnt_r + inflight_r − (yumi_i & v_o) < out_els_p).
  - ready_o must not depend on v_i, w_i or addr_i combinationally; yumi_i may feed it.
- Accepted write, cycle t:
  - mem[addr] updated at the posedge ending t.
  - Only bytes with w_mask_i=1 change; masked-off bytes keep their old value.
  - w_mask_i=0 is a legal no-op write.
- Accepted read, cycle t:
  - SRAM output is valid in cycle t+1.
  - If the FIFO is empty in t+1, the SRAM output bypasses to data_o with v_o=1 in t+1.
  - Otherwise the word is enqueued behind older entries.
  - If yumi_i is not asserted in t+1, the word is captured into the FIFO at the end of t+1.
  - Data is never dropped and never re-read from the SRAM.
- Read-after-write to the same address on consecutive accepted requests returns the newly written data. The SRAM is written before the read cycle, so no bypass is needed.
- Ordering: read data is returned strictly in request order.
- With v_o=1 and yumi_i=0, data_o is stable cycle to cycle.
- Simultaneous enqueue and yumi with a full FIFO is allowed. This case arises only through the credit rule above.
- Reset mid-operation: in-flight and buffered reads are discarded and v_o=0 the next cycle. Memory writes already committed persist.
- Assertions (translate_off):
  - addr_i < els_p when v_i & ready_o, with reset_n_i high.
  - No yumi_i without v_o.
  - reset_n_i not X after the first cycle.

Optional Feature:
- Macro: BSG_MEM_1RW_SYNC_MASK_FIFO_OUT_INIT_EN.
- Defined:
  - eRESET → eINIT on reset release.
  - eINIT writes all-zeros with a full mask to addresses 0..els_p−1, one per cycle, using an internal counter.
  - eINIT → eREADY after the write of address els_p−1.
  - ready_o=0 throughout eINIT, so ready_o first rises els_p+1 cycles after reset release.
  - Reset during eINIT restarts the sweep at address 0.
- Undefined:
  - No eINIT state and no counter.
  - ready_o rises the first cycle after reset release.
  - Memory powers up as X.

Test Plan:
- Reset, write: after reset release, write addr 5 = 0x0123456789ABCDEF with mask 0xFF, then read addr 5 → v_o=1 exactly one cycle after read acceptance, data_o=0x0123456789ABCDEF.
- Masked write: write addr 5 = 0xFFFF_FFFF_FFFF_FFFF with mask 0x0F, then read → data_o=0x01234567FFFFFFFF.
- Backpressure: hold yumi_i=0 and issue reads to addrs 1,2,3 back-to-back → only 2 accepted (ready_o drops). Data stays stable on data_o. Release yumi_i → values returned in order 1,2, then the 3rd read is accepted.
- Throughput: yumi_i tied to v_o with 100 consecutive reads → one read accepted per cycle, v_o continuous after the first cycle, and no bubbles.
- Reset mid-flight: with 2 words buffered, pulse reset_n_i=0 for 1 cycle → v_o=0 next cycle. A previously written addr still reads back its old value.
- With INIT_EN and els_p=16: after reset release, ready_o=0 for 17 cycles, then reads of addrs 0..15 return 0.
